// File: rtl/l2_arbiter.sv
// Round-robin arbiter that merges the split L1 I/D cache line ports onto one L2 port.
// One line transaction at a time; per-client saturating grant counters for monitoring.
module l2_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  input  logic                  i_pmem_read,
  input  logic                  i_pmem_write,
  input  logic [LINE_WIDTH-1:0] i_pmem_wdata,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic [ADDR_WIDTH-1:0] l2_mem_address,
  output logic [LINE_WIDTH-1:0] l2_mem_wdata,
  output logic                  l2_mem_read,
  output logic                  l2_mem_write,
  input  logic [LINE_WIDTH-1:0] l2_mem_rdata,
  input  logic                  l2_mem_resp,
  output logic [CNT_WIDTH-1:0]  i_grant_count,
  output logic [CNT_WIDTH-1:0]  d_grant_count,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               r_state;
  state_t               w_next;
  logic                 r_last_d;   // 1 when D was the last client granted
  logic [CNT_WIDTH-1:0] r_i_cnt;
  logic [CNT_WIDTH-1:0] r_d_cnt;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;

  assign w_i_req   = i_pmem_read | i_pmem_write;
  assign w_d_req   = d_pmem_read | d_pmem_write;
  // A grant is any transition into a SERVE state, including SERVE_x -> SERVE_y hand-offs.
  assign w_grant_i = (w_next == SERVE_I) && (r_state != SERVE_I);
  assign w_grant_d = (w_next == SERVE_D) && (r_state != SERVE_D);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_i_req && w_d_req) w_next = r_last_d ? SERVE_I : SERVE_D;
        else if (w_i_req)       w_next = SERVE_I;
        else if (w_d_req)       w_next = SERVE_D;
      end
      SERVE_I: if (l2_mem_resp) w_next = w_d_req ? SERVE_D : IDLE;
      SERVE_D: if (l2_mem_resp) w_next = w_i_req ? SERVE_I : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_d <= 1'b1;
      r_i_cnt  <= '0;
      r_d_cnt  <= '0;
    end else begin
      if (w_grant_i) begin
        r_last_d <= 1'b0;
        if (r_i_cnt != '1) r_i_cnt <= r_i_cnt + CNT_ONE;
      end
      if (w_grant_d) begin
        r_last_d <= 1'b1;
        if (r_d_cnt != '1) r_d_cnt <= r_d_cnt + CNT_ONE;
      end
    end
  end

  always_comb begin
    l2_mem_address = '0;
    l2_mem_wdata   = '0;
    l2_mem_read    = 1'b0;
    l2_mem_write   = 1'b0;
    i_pmem_rdata   = '0;
    i_pmem_resp    = 1'b0;
    d_pmem_rdata   = '0;
    d_pmem_resp    = 1'b0;
    case (r_state)
      SERVE_I: begin
        l2_mem_address = i_pmem_address;
        l2_mem_wdata   = i_pmem_wdata;
        l2_mem_write   = i_pmem_write;
        l2_mem_read    = i_pmem_read & ~i_pmem_write;  // write wins when both are high
        i_pmem_resp    = l2_mem_resp;
        if (l2_mem_resp) i_pmem_rdata = l2_mem_rdata;
      end
      SERVE_D: begin
        l2_mem_address = d_pmem_address;
        l2_mem_wdata   = d_pmem_wdata;
        l2_mem_write   = d_pmem_write;
        l2_mem_read    = d_pmem_read & ~d_pmem_write;
        d_pmem_resp    = l2_mem_resp;
        if (l2_mem_resp) d_pmem_rdata = l2_mem_rdata;
      end
      default: ;
    endcase
  end

  assign busy          = (r_state != IDLE);
  assign i_grant_count = r_i_cnt;
  assign d_grant_count = r_d_cnt;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter; a second 2-bit-counter instance shares all stimulus
// so counter saturation is reached within a few grants.
module tb_l2_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] i_addr, d_addr;
  logic          i_rd, i_wr, d_rd, d_wr;
  logic [LW-1:0] i_wd, d_wd;
  logic [LW-1:0] l2_rdata;
  logic          l2_resp;

  logic [LW-1:0] i_rdata, d_rdata, l2_wdata;
  logic          i_resp, d_resp, l2_rd, l2_wr, busy;
  logic [AW-1:0] l2_addr;
  logic [CW-1:0] i_cnt, d_cnt;

  logic [LW-1:0] s_i_rdata, s_d_rdata, s_l2_wdata;
  logic          s_i_resp, s_d_resp, s_l2_rd, s_l2_wr, s_busy;
  logic [AW-1:0] s_l2_addr;
  logic [1:0]    s_i_cnt, s_d_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [LW-1:0] line_a;
  logic [LW-1:0] line_5a;
  logic [LW-1:0] line_c;
  logic          serve_i;

  always #5 clk = ~clk;

  l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .i_pmem_address(i_addr), .i_pmem_read(i_rd), .i_pmem_write(i_wr), .i_pmem_wdata(i_wd),
    .i_pmem_rdata(i_rdata), .i_pmem_resp(i_resp),
    .d_pmem_address(d_addr), .d_pmem_read(d_rd), .d_pmem_write(d_wr), .d_pmem_wdata(d_wd),
    .d_pmem_rdata(d_rdata), .d_pmem_resp(d_resp),
    .l2_mem_address(l2_addr), .l2_mem_wdata(l2_wdata), .l2_mem_read(l2_rd), .l2_mem_write(l2_wr),
    .l2_mem_rdata(l2_rdata), .l2_mem_resp(l2_resp),
    .i_grant_count(i_cnt), .d_grant_count(d_cnt), .busy(busy)
  );

  l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset),
    .i_pmem_address(i_addr), .i_pmem_read(i_rd), .i_pmem_write(i_wr), .i_pmem_wdata(i_wd),
    .i_pmem_rdata(s_i_rdata), .i_pmem_resp(s_i_resp),
    .d_pmem_address(d_addr), .d_pmem_read(d_rd), .d_pmem_write(d_wr), .d_pmem_wdata(d_wd),
    .d_pmem_rdata(s_d_rdata), .d_pmem_resp(s_d_resp),
    .l2_mem_address(s_l2_addr), .l2_mem_wdata(s_l2_wdata), .l2_mem_read(s_l2_rd), .l2_mem_write(s_l2_wr),
    .l2_mem_rdata(l2_rdata), .l2_mem_resp(l2_resp),
    .i_grant_count(s_i_cnt), .d_grant_count(s_d_cnt), .busy(s_busy)
  );

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    i_addr = '0; i_rd = 1'b0; i_wr = 1'b0; i_wd = '0;
    d_addr = '0; d_rd = 1'b0; d_wr = 1'b0; d_wd = '0;
    l2_rdata = '0; l2_resp = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset released and the arbiter in IDLE.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    line_a  = {32{4'hA}};
    line_5a = {16{8'h5A}};
    line_c  = {32{4'hC}};

    // Reset values
    do_reset();
    #1;
    check("rst_busy", busy, 0);
    check("rst_l2_rd", l2_rd, 0);
    check("rst_l2_wr", l2_wr, 0);
    check("rst_l2_addr", l2_addr, 0);
    check("rst_i_cnt", i_cnt, 0);
    check("rst_d_cnt", d_cnt, 0);
    check("rst_i_resp", i_resp, 0);

    // I-cache read alone: one cycle to the L2 request, response after 3 cycles
    i_addr = 16'h1230; i_rd = 1'b1;
    #1;
    check("t1_idle_l2_rd", l2_rd, 0);
    @(negedge clk); #1;
    check("t1_l2_rd", l2_rd, 1);
    check("t1_l2_addr", l2_addr, 16'h1230);
    check("t1_busy", busy, 1);
    check("t1_i_cnt", i_cnt, 1);
    @(negedge clk); #1;
    check("t1_no_resp_yet", i_resp, 0);
    @(negedge clk);
    l2_resp = 1'b1; l2_rdata = line_a;
    #1;
    check("t1_i_resp", i_resp, 1);
    check("t1_i_rdata", i_rdata, line_a);
    check("t1_d_resp", d_resp, 0);
    check("t1_d_rdata", d_rdata, 0);
    @(negedge clk);
    i_rd = 1'b0; l2_resp = 1'b0;
    #1;
    check("t1_back_idle", busy, 0);
    check("t1_idle_l2_rd_off", l2_rd, 0);

    // Simultaneous I read / D write: I first, then D with no IDLE bubble
    do_reset();
    i_addr = 16'h0040; i_rd = 1'b1;
    d_addr = 16'h8000; d_wr = 1'b1; d_wd = line_c;
    @(negedge clk); #1;
    check("t2_first_addr", l2_addr, 16'h0040);
    check("t2_first_rd", l2_rd, 1);
    l2_resp = 1'b1; l2_rdata = line_a;
    #1;
    check("t2_i_resp", i_resp, 1);
    check("t2_d_resp_low", d_resp, 0);
    @(negedge clk);
    i_rd = 1'b0; l2_resp = 1'b0;
    #1;
    check("t2_no_bubble", busy, 1);
    check("t2_l2_wr", l2_wr, 1);
    check("t2_l2_rd", l2_rd, 0);
    check("t2_l2_addr", l2_addr, 16'h8000);
    check("t2_l2_wdata", l2_wdata, line_c);
    l2_resp = 1'b1;
    #1;
    check("t2_d_resp", d_resp, 1);
    check("t2_i_resp_low", i_resp, 0);
    @(negedge clk);
    d_wr = 1'b0; l2_resp = 1'b0;
    #1;
    check("t2_i_cnt", i_cnt, 1);
    check("t2_d_cnt", d_cnt, 1);
    check("t2_idle", busy, 0);

    // Continuous contention: ten alternating grants; 2-bit instance saturates its counters
    do_reset();
    i_addr = 16'h0100; i_rd = 1'b1;
    d_addr = 16'h0200; d_rd = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      l2_resp = 1'b1; l2_rdata = LW'(t + 1);
      if (t == 9) i_rd = 1'b0;
      #1;
      serve_i = (t % 2 == 0);
      check("t3_addr", l2_addr, serve_i ? 16'h0100 : 16'h0200);
      check("t3_i_resp", i_resp, serve_i);
      check("t3_d_resp", d_resp, !serve_i);
      check("t3_rdata", serve_i ? i_rdata : d_rdata, LW'(t + 1));
      check("t3_i_cnt", i_cnt, (t + 2) / 2);
      check("t3_d_cnt", d_cnt, (t + 1) / 2);
      if (!serve_i) check("t3_sat_d_cnt", s_d_cnt, ((t + 1) / 2 > 3) ? 3 : (t + 1) / 2);
    end
    @(negedge clk);
    d_rd = 1'b0; l2_resp = 1'b0;
    #1;
    check("t3_idle", busy, 0);
    check("t3_i_cnt_final", i_cnt, 5);
    check("t3_d_cnt_final", d_cnt, 5);
    check("t4_sat_i_cnt", s_i_cnt, 3);
    check("t4_sat_d_cnt", s_d_cnt, 3);

    // Reset in the middle of SERVE_D
    do_reset();
    d_addr = 16'h0300; d_rd = 1'b1;
    @(negedge clk); #1;
    check("t5_serving", l2_rd, 1);
    check("t5_d_cnt", d_cnt, 1);
    reset = 1'b1; l2_resp = 1'b1;
    #1;
    check("t5_l2_rd", l2_rd, 0);
    check("t5_l2_addr", l2_addr, 0);
    check("t5_busy", busy, 0);
    check("t5_d_cnt_clr", d_cnt, 0);
    check("t5_d_resp", d_resp, 0);
    @(negedge clk);
    reset = 1'b0; d_rd = 1'b0; l2_resp = 1'b0;
    #1;
    check("t5_stays_idle", busy, 0);

    // D read+write together, and L2 resp while IDLE
    d_addr = 16'h0440; d_rd = 1'b1; d_wr = 1'b1; d_wd = line_5a;
    l2_resp = 1'b1; l2_rdata = line_a;
    #1;
    check("t6_idle_d_resp", d_resp, 0);
    check("t6_idle_i_resp", i_resp, 0);
    check("t6_idle_d_rdata", d_rdata, 0);
    @(negedge clk);
    l2_resp = 1'b0;
    #1;
    check("t6_l2_wr", l2_wr, 1);
    check("t6_l2_rd", l2_rd, 0);
    check("t6_l2_wdata", l2_wdata, line_5a);
    check("t6_l2_addr", l2_addr, 16'h0440);
    l2_resp = 1'b1;
    #1;
    check("t6_d_resp", d_resp, 1);
    @(negedge clk);
    d_rd = 1'b0; d_wr = 1'b0; l2_resp = 1'b0;
    #1;
    check("t6_idle", busy, 0);

    // D drops its request before the response; arbiter still waits for l2_mem_resp
    d_addr = 16'h0500; d_rd = 1'b1;
    @(negedge clk);
    d_rd = 1'b0;
    #1;
    check("t7_l2_rd_drop", l2_rd, 0);
    check("t7_still_busy", busy, 1);
    @(negedge clk); #1;
    check("t7_waits", busy, 1);
    l2_resp = 1'b1; l2_rdata = line_c;
    #1;
    check("t7_d_resp", d_resp, 1);
    @(negedge clk);
    l2_resp = 1'b0;
    #1;
    check("t7_idle", busy, 0);
    check("t7_d_cnt", d_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
